// File: rtl/down_count_sequencer_if.sv
// Control/status bundle between a countdown sequencer and the logic that drives it.
// The master issues commands and reads status; the slave is the sequencer itself.
interface down_count_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             pause;
    logic             reload_en;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output start, abort, pause, reload_en, load_val,
        input  count, busy, done, wrap
    );

    modport slave (
        input  start, abort, pause, reload_en, load_val,
        output count, busy, done, wrap
    );
endinterface

// File: rtl/down_count_sequencer.sv
// Start/stop-able down-counter: decrements by STEP once every PRESCALE unpaused
// cycles, with abort, pause and optional auto-reload of the latched start value.
module down_count_sequencer #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 2,
    parameter int PRESCALE  = 1,
    parameter int EVEN_ONLY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    down_count_sequencer_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Prescaler needs at least one bit even when PRESCALE=1 (it then stays at 0).
    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_r, count_nxt;
    logic [WIDTH-1:0] reload_r, reload_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             done_r, done_nxt;
    logic             wrap_r, wrap_nxt;
    logic [WIDTH-1:0] eff_val;
    logic             tick;

    assign eff_val = (EVEN_ONLY != 0) ? {bus.load_val[WIDTH-1:1], 1'b0} : bus.load_val;
    assign tick    = (presc == PRE_LAST) && !bus.pause;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count_r  <= '0;
            reload_r <= '0;
            presc    <= '0;
            done_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_r  <= count_nxt;
            reload_r <= reload_nxt;
            presc    <= presc_nxt;
            done_r   <= done_nxt;
            wrap_r   <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_r;
        reload_nxt = reload_r;
        presc_nxt  = presc;
        done_nxt   = 1'b0;
        wrap_nxt   = 1'b0;
        if (bus.abort) begin
            // Abort outranks everything else and deliberately raises no pulse.
            state_nxt = IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (eff_val != '0) begin
                            state_nxt  = RUN;
                            count_nxt  = eff_val;
                            reload_nxt = eff_val;
                            presc_nxt  = '0;
                        end else begin
                            count_nxt = '0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        presc_nxt = (presc == PRE_LAST) ? '0 : presc + 1'b1;
                    end
                    if (tick) begin
                        if (count_r > STEP_W) begin
                            count_nxt = count_r - STEP_W;
                        end else if (bus.reload_en) begin
                            count_nxt = reload_r;
                            wrap_nxt  = 1'b1;
                        end else begin
                            count_nxt = '0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.count = count_r;
        bus.busy  = (state == RUN);
        bus.done  = done_r;
        bus.wrap  = wrap_r;
    end
endmodule
